lsu_stage: RTL and testbench

- Multi-cycle load/store unit, between EXU and WBU.
- Accepts one instruction bundle from EXU and performs at most one data-memory access over a valid/ready request plus response-valid bus.
- Packs the 104-bit writeback bundle and hands it to WBU with a single-cycle lsu_valid pulse.
- Sole producer of lsu_valid/lsu_data.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_align.sv | 30 +++
 rtl/lsu_stage.sv | 98 +++++++++
 tb/tb_lsu_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared mem_op encodings, bundle field offsets and LSU state type
package lsu_pkg;
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam int EXU_W  = 109;
  localparam int LSU_W  = 104;
  localparam int EX_ALU = 77;
  localparam int EX_SD  = 45;
  localparam int EX_REN = 44;
  localparam int EX_WEN = 43;
  localparam int EX_OP  = 40;
  localparam int EX_RDW = 39;
  localparam int EX_RDA = 34;
  localparam int EX_SEL = 32;
  localparam int EX_CSR = 0;
  localparam int LS_ALU = 72;
  localparam int LS_LD  = 40;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load extract/extend, store lane/mask generation, misalign detection
module lsu_align import lsu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       addr,
  input  logic [2:0]       op,
  input  logic             wen,
  input  logic [WIDTH-1:0] sdata,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] wdata,
  output logic [3:0]       wmask,
  output logic [WIDTH-1:0] ldata,
  output logic             misalign
);
  logic is_b, is_h, uns;
  logic [7:0] b;
  logic [15:0] h;
  // stores decode only SB/SH exactly, loads also accept the unsigned forms; everything else is a word
  always_comb begin
    is_b = wen ? op == OP_B : (op == OP_B || op == OP_BU);
    is_h = wen ? op == OP_H : (op == OP_H || op == OP_HU);
    uns = op == OP_BU || op == OP_HU;
    b = rdata[{addr, 3'b000} +: 8];
    h = rdata[{addr[1], 4'b0000} +: 16];
    misalign = is_h ? addr[0] : (is_b ? 1'b0 : |addr);
    wdata = is_b ? {4{sdata[7:0]}} : (is_h ? {2{sdata[15:0]}} : sdata);
    wmask = !wen ? 4'b0000 : (is_b ? 4'b0001 << addr : (is_h ? 4'b0011 << {addr[1], 1'b0} : 4'b1111));
    ldata = is_b ? {{24{~uns & b[7]}}, b} : (is_h ? {{16{~uns & h[15]}}, h} : rdata);
  end
endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: multi-cycle load/store unit between EXU and WBU
module lsu_stage import lsu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic [EXU_W-1:0] exu_data,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_req_addr,
  output logic             mem_req_wen,
  output logic [WIDTH-1:0] mem_req_wdata,
  output logic [3:0]       mem_req_wmask,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_resp_rdata,
  output logic             lsu_valid,
  output logic [LSU_W-1:0] lsu_data,
  output logic             lsu_misalign
);
  state_t state;
  logic [EXU_W-1:0] bun, cur;
  logic [WIDTH-1:0] wdata, ldata;
  logic [3:0] wmask;
  logic a_mis, mem, mis, go_req;
  logic [LSU_W-1:0] done_data;
  // in IDLE the incoming bundle drives decode so the accept decision is made the same cycle
  always_comb begin
    cur = state == IDLE ? exu_data : bun;
    mem = cur[EX_REN] | cur[EX_WEN];
    mis = mem & a_mis;
    go_req = mem & ~a_mis;
    done_data = {cur[EX_ALU +: WIDTH],
                 (state == RESP && cur[EX_REN] && !cur[EX_WEN]) ? ldata : {WIDTH{1'b0}},
                 cur[EX_RDW] & ~mis, cur[EX_RDA +: 5], cur[EX_SEL +: 2], cur[EX_CSR +: 32]};
  end
  lsu_align #(.WIDTH(WIDTH)) u_align (
    .addr(cur[EX_ALU +: 2]),
    .op(cur[EX_OP +: 3]),
    .wen(cur[EX_WEN]),
    .sdata(cur[EX_SD +: WIDTH]),
    .rdata(mem_resp_rdata),
    .wdata(wdata),
    .wmask(wmask),
    .ldata(ldata),
    .misalign(a_mis)
  );
  // FSM with registered handshake, request and writeback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bun <= '0;
      exu_ready <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_addr <= '0;
      mem_req_wen <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      lsu_valid <= 1'b0;
      lsu_misalign <= 1'b0;
      lsu_data <= '0;
    end else begin
      lsu_valid <= 1'b0;
      lsu_misalign <= 1'b0;
      case (state)
        IDLE: if (exu_valid) begin
          bun <= exu_data;
          exu_ready <= 1'b0;
          state <= go_req ? REQ : DONE;
          mem_req_valid <= go_req;
          lsu_valid <= ~go_req;
          lsu_misalign <= mis;
          if (go_req) begin
            mem_req_addr <= cur[EX_ALU +: WIDTH];
            mem_req_wen <= cur[EX_WEN];
            mem_req_wdata <= wdata;
            mem_req_wmask <= wmask;
          end else
            lsu_data <= done_data;
        end
        REQ: if (mem_req_ready) begin
          state <= RESP;
          mem_req_valid <= 1'b0;
        end
        RESP: if (mem_resp_valid) begin
          state <= DONE;
          lsu_valid <= 1'b1;
          lsu_data <= done_data;
        end
        default: begin
          state <= IDLE;
          exu_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed self-checking bench for lsu_stage
module tb_lsu_stage;
  import lsu_pkg::*;
  logic clk = 1'b0;
  logic rst, exu_valid, exu_ready, mem_req_valid, mem_req_ready, mem_req_wen;
  logic mem_resp_valid, lsu_valid, lsu_misalign;
  logic [108:0] exu_data;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [3:0] mem_req_wmask;
  logic [103:0] lsu_data;
  int vec = 0;
  int err = 0;

  lsu_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_data(exu_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .lsu_valid(lsu_valid), .lsu_data(lsu_data), .lsu_misalign(lsu_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [108:0] mk(input logic [31:0] alu, input logic [31:0] sd, input logic ren,
                                      input logic wen, input logic [2:0] op, input logic rdw,
                                      input logic [4:0] rda, input logic [1:0] sel, input logic [31:0] csr);
    return {alu, sd, ren, wen, op, rdw, rda, sel, csr};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; exu_valid = 1'b0; exu_data = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    tick; tick;
    rst = 1'b0;
    vec++; if (exu_ready !== 1'b1) begin err++; $display("FAIL reset_exu_ready: got %b expected 1", exu_ready); end
    vec++; if (mem_req_valid !== 1'b0) begin err++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
    vec++; if ({lsu_valid, lsu_misalign} !== 2'b00) begin err++; $display("FAIL reset_lsu_valid_mis: got %b expected 00", {lsu_valid, lsu_misalign}); end
    vec++; if (lsu_data !== 104'h0) begin err++; $display("FAIL reset_lsu_data: got %h expected 0", lsu_data); end
    vec++; if (mem_req_wmask !== 4'b0000) begin err++; $display("FAIL reset_wmask: got %b expected 0000", mem_req_wmask); end
  endtask

  task automatic test_nonmem;
    exu_data = mk(32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 2'b00, 32'hCAFE);
    exu_valid = 1'b1;
    tick;
    exu_valid = 1'b0;
    vec++; if ({lsu_valid, exu_ready} !== 2'b10) begin err++; $display("FAIL nonmem_pulse: got valid,ready=%b expected 10", {lsu_valid, exu_ready}); end
    vec++; if (lsu_data !== {32'h1234, 32'h0, 1'b1, 5'd5, 2'b00, 32'hCAFE}) begin err++; $display("FAIL nonmem_data: got %h", lsu_data); end
    tick;
    vec++; if ({lsu_valid, exu_ready} !== 2'b01) begin err++; $display("FAIL nonmem_after: got valid,ready=%b expected 01", {lsu_valid, exu_ready}); end
  endtask

  task automatic test_load(input string nm, input logic [31:0] addr, input logic [2:0] op,
                           input logic [31:0] rd, input logic [31:0] exp);
    exu_data = mk(addr, 32'hDEAD, 1'b1, 1'b0, op, 1'b1, 5'd7, 2'b01, 32'h55);
    exu_valid = 1'b1;
    tick;
    exu_valid = 1'b0;
    vec++; if ({mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr} !== {1'b1, 1'b0, 4'b0000, addr}) begin
      err++; $display("FAIL %s_req: got v,wen,mask,addr=%b %b %b %h expected 1 0 0000 %h", nm, mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr, addr);
    end
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = rd;
    tick;
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    vec++; if ({lsu_valid, lsu_data} !== {1'b1, addr, exp, 1'b1, 5'd7, 2'b01, 32'h55}) begin
      err++; $display("FAIL %s_data: got valid=%b load=%h expected 1 %h", nm, lsu_valid, lsu_data[71:40], exp);
    end
    tick;
    vec++; if (lsu_valid !== 1'b0) begin err++; $display("FAIL %s_pulse_width: got %b expected 0", nm, lsu_valid); end
  endtask

  task automatic test_store(input string nm, input logic [31:0] addr, input logic [2:0] op,
                            input logic [31:0] sd, input logic [3:0] emask, input logic [31:0] ewd, input int stall);
    exu_data = mk(addr, sd, 1'b0, 1'b1, op, 1'b0, 5'd0, 2'b00, 32'h0);
    exu_valid = 1'b1;
    tick;
    exu_valid = 1'b0;
    exu_data = mk(~addr, ~sd, 1'b1, 1'b0, 3'b010, 1'b1, 5'd31, 2'b11, 32'hFFFF_FFFF);
    for (int i = 0; i < stall; i++) begin
      vec++; if ({mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata} !== {1'b1, 1'b1, emask, addr, ewd}) begin
        err++; $display("FAIL %s_req_c%0d: got v,wen,mask,addr,wdata=%b %b %b %h %h expected 1 1 %b %h %h", nm, i, mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr, mem_req_wdata, emask, addr, ewd);
      end
      if (i < stall - 1) tick;
    end
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    vec++; if ({mem_req_valid, lsu_valid} !== 2'b00) begin err++; $display("FAIL %s_after_ack: got reqv,lsuv=%b expected 00", nm, {mem_req_valid, lsu_valid}); end
    mem_resp_valid = 1'b1;
    tick;
    mem_resp_valid = 1'b0;
    vec++; if ({lsu_valid, lsu_data} !== {1'b1, addr, 32'h0, 1'b0, 5'd0, 2'b00, 32'h0}) begin
      err++; $display("FAIL %s_done: got valid=%b data=%h", nm, lsu_valid, lsu_data);
    end
    tick;
  endtask

  task automatic test_misalign(input string nm, input logic [31:0] addr, input logic [2:0] op, input logic wen);
    exu_data = mk(addr, 32'h0, ~wen, wen, op, 1'b1, 5'd9, 2'b10, 32'h77);
    exu_valid = 1'b1;
    tick;
    exu_valid = 1'b0;
    vec++; if ({lsu_valid, lsu_misalign, mem_req_valid} !== 3'b110) begin err++; $display("FAIL %s_flags: got valid,mis,reqv=%b expected 110", nm, {lsu_valid, lsu_misalign, mem_req_valid}); end
    vec++; if (lsu_data !== {addr, 32'h0, 1'b0, 5'd9, 2'b10, 32'h77}) begin err++; $display("FAIL %s_data: got %h", nm, lsu_data); end
    tick;
    vec++; if ({lsu_valid, lsu_misalign, mem_req_valid} !== 3'b000) begin err++; $display("FAIL %s_after: got valid,mis,reqv=%b expected 000", nm, {lsu_valid, lsu_misalign, mem_req_valid}); end
  endtask

  task automatic test_reset_in_resp;
    exu_data = mk(32'h200, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd3, 2'b00, 32'h0);
    exu_valid = 1'b1;
    tick;
    exu_valid = 1'b0; mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBEEF;
    tick;
    mem_resp_valid = 1'b0;
    vec++; if ({lsu_valid, exu_ready, mem_req_valid} !== 3'b010) begin err++; $display("FAIL rst_resp_flags: got valid,ready,reqv=%b expected 010", {lsu_valid, exu_ready, mem_req_valid}); end
    vec++; if (lsu_data !== 104'h0) begin err++; $display("FAIL rst_resp_data: got %h expected 0", lsu_data); end
    tick;
    vec++; if (lsu_valid !== 1'b0) begin err++; $display("FAIL rst_resp_late: got %b expected 0", lsu_valid); end
  endtask

  task automatic test_resp_in_req;
    exu_data = mk(32'h300, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd4, 2'b00, 32'h0);
    exu_valid = 1'b1;
    tick;
    exu_valid = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD;
    tick;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    tick;
    vec++; if (lsu_valid !== 1'b0) begin err++; $display("FAIL req_resp_early: got %b expected 0", lsu_valid); end
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h600D;
    tick;
    mem_resp_valid = 1'b0;
    vec++; if ({lsu_valid, lsu_data[71:40]} !== {1'b1, 32'h600D}) begin err++; $display("FAIL req_resp_data: got valid=%b load=%h expected 1 0000600d", lsu_valid, lsu_data[71:40]); end
    tick;
  endtask

  task automatic test_back_to_back;
    exu_data = mk(32'h11, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd1, 2'b00, 32'h0);
    exu_valid = 1'b1;
    tick;
    exu_data = mk(32'h22, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd2, 2'b00, 32'h0);
    vec++; if ({lsu_valid, lsu_data[103:72]} !== {1'b1, 32'h11}) begin err++; $display("FAIL b2b_first: got valid=%b alu=%h expected 1 00000011", lsu_valid, lsu_data[103:72]); end
    tick;
    vec++; if ({lsu_valid, exu_ready, lsu_data[103:72]} !== {1'b0, 1'b1, 32'h11}) begin err++; $display("FAIL b2b_gap: got valid=%b ready=%b alu=%h expected 0 1 00000011", lsu_valid, exu_ready, lsu_data[103:72]); end
    tick;
    exu_valid = 1'b0;
    vec++; if ({lsu_valid, lsu_data[103:72]} !== {1'b1, 32'h22}) begin err++; $display("FAIL b2b_second: got valid=%b alu=%h expected 1 00000022", lsu_valid, lsu_data[103:72]); end
    tick;
    vec++; if ({lsu_valid, exu_ready} !== 2'b01) begin err++; $display("FAIL b2b_end: got valid,ready=%b expected 01", {lsu_valid, exu_ready}); end
  endtask

  initial begin
    test_reset;
    test_nonmem;
    test_load("lb", 32'h8003, OP_B, 32'h80FF_FFFF, 32'hFFFF_FF80);
    test_load("lbu", 32'h8003, OP_BU, 32'h80FF_FFFF, 32'h0000_0080);
    test_load("lh", 32'h8002, OP_H, 32'h8001_0000, 32'hFFFF_8001);
    test_load("lhu", 32'h8000, OP_HU, 32'h1234_F00D, 32'h0000_F00D);
    test_load("lw", 32'h8004, 3'b010, 32'h1234_5678, 32'h1234_5678);
    test_store("sh", 32'h102, OP_H, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 3);
    test_store("sb", 32'h101, OP_B, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A, 1);
    test_store("sw", 32'h104, 3'b010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1);
    test_misalign("lw_mis", 32'h101, 3'b010, 1'b0);
    test_misalign("lh_mis", 32'h8001, OP_H, 1'b0);
    test_misalign("sw_mis", 32'h102, 3'b010, 1'b1);
    test_reset_in_resp;
    test_resp_in_req;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
